multi_cycle_control: RTL and testbench

Main control state machine for the 16-bit multi-cycle processor; sits directly upstream of the calculations (execute) stage and drives its ALUOp, ALUSrcA, ALUSrcB and PCSrc selects each cycle. It also sequences PC, instruction-register, memory and register-file writes. It consumes the ALU Zero and negative flags fed back from that stage to resolve branches. One instruction is in flight at a time.

---
 rtl/multi_cycle_control.sv | 270 +++++++++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// multi_cycle_control
// Main control FSM for the 16-bit multi-cycle processor. Sequences fetch,
// decode, execute, memory and write-back for one instruction at a time and
// drives the execute-stage selects (ALUOp, ALUSrcA, ALUSrcB, PCSrc) plus the
// PC / IR / memory / register-file strobes.
// Optional feature macro: CONTROL_BLT_EN -- when defined, opcode 7 is BLT and
// branches on input_negative; when undefined, opcode 7 is an illegal opcode.
// Outputs are decoded from the registered state; the only input-dependent
// terms are the FETCH write enables (mem_ready), the EXEC_R ALUOp (funct),
// the BRANCH PCWrite (live ALU flags) and the DECODE illegal pulse.

module multi_cycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          input_opcode,
    input  logic [2:0]          input_funct,
    input  logic                input_Zero,
    input  logic                input_negative,
    input  logic                input_mem_ready,
    output logic [2:0]          output_ALUOp,
    output logic [1:0]          output_ALUSrcA,
    output logic [1:0]          output_ALUSrcB,
    output logic                output_PCSrc,
    output logic                output_PCWrite,
    output logic                output_IRWrite,
    output logic                output_MemRead,
    output logic                output_MemWrite,
    output logic                output_IorD,
    output logic                output_RegWrite,
    output logic                output_MemtoReg,
    output logic                output_RegDst,
    output logic [3:0]          output_state,
    output logic                output_illegal,
    output logic                output_halted,
    output logic [RETIRE_W-1:0] output_retired
);

    // State encodings (fixed; visible on output_state)
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] EXEC_R    = 4'd3;
    localparam logic [3:0] EXEC_I    = 4'd4;
    localparam logic [3:0] ALU_WB    = 4'd5;
    localparam logic [3:0] MEM_ADDR  = 4'd6;
    localparam logic [3:0] MEM_READ  = 4'd7;
    localparam logic [3:0] MEM_WB    = 4'd8;
    localparam logic [3:0] MEM_WRITE = 4'd9;
    localparam logic [3:0] BRANCH    = 4'd10;
    localparam logic [3:0] JUMP      = 4'd11;
    localparam logic [3:0] HALT      = 4'd12;

    // Opcodes
    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;
    localparam logic [3:0] OP_BLT  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

`ifdef CONTROL_BLT_EN
    localparam logic BLT_EN = 1'b1;
`else
    localparam logic BLT_EN = 1'b0;
`endif

    // True for every opcode the machine knows how to execute
    function automatic logic opcode_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_R, OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_HALT: legal = 1'b1;
            OP_BLT:                        legal = BLT_EN;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    logic [3:0]          state_r;
    logic [3:0]          state_nxt_s;
    logic                r_type_r;
    logic [RETIRE_W-1:0] retired_r;
    logic                retire_s;
    logic                illegal_s;
    logic                branch_taken_s;

    // Next-state selection plus the retire and illegal-opcode events
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        illegal_s   = 1'b0;
        case (state_r)
            IDLE: state_nxt_s = FETCH;
            FETCH: begin
                if (input_mem_ready) begin
                    state_nxt_s = DECODE;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DECODE: begin
                if (!opcode_is_legal(input_opcode)) begin
                    illegal_s   = 1'b1;
                    state_nxt_s = FETCH;
                end else begin
                    case (input_opcode)
                        OP_R:                  state_nxt_s = EXEC_R;
                        OP_ADDI:               state_nxt_s = EXEC_I;
                        OP_LW, OP_SW:          state_nxt_s = MEM_ADDR;
                        OP_BEQ, OP_BNE, OP_BLT: state_nxt_s = BRANCH;
                        OP_J:                  state_nxt_s = JUMP;
                        OP_HALT:               state_nxt_s = HALT;
                        default:               state_nxt_s = FETCH;
                    endcase
                end
            end
            EXEC_R: state_nxt_s = ALU_WB;
            EXEC_I: state_nxt_s = ALU_WB;
            ALU_WB: begin
                retire_s    = 1'b1;
                state_nxt_s = FETCH;
            end
            MEM_ADDR: begin
                if (input_opcode == OP_LW) begin
                    state_nxt_s = MEM_READ;
                end else begin
                    state_nxt_s = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (input_mem_ready) begin
                    state_nxt_s = MEM_WB;
                end else begin
                    state_nxt_s = MEM_READ;
                end
            end
            MEM_WB: begin
                retire_s    = 1'b1;
                state_nxt_s = FETCH;
            end
            MEM_WRITE: begin
                if (input_mem_ready) begin
                    retire_s    = 1'b1;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = MEM_WRITE;
                end
            end
            BRANCH: begin
                retire_s    = 1'b1;
                state_nxt_s = FETCH;
            end
            JUMP: begin
                retire_s    = 1'b1;
                state_nxt_s = FETCH;
            end
            HALT: state_nxt_s = HALT;
            // Unreachable encodings fall back to a clean restart
            default: state_nxt_s = IDLE;
        endcase
    end

    // Branch condition evaluated on the live ALU flags of this cycle
    always_comb begin
        case (input_opcode)
            OP_BEQ:  branch_taken_s = input_Zero;
            OP_BNE:  branch_taken_s = !input_Zero;
            OP_BLT:  branch_taken_s = BLT_EN & input_negative;
            default: branch_taken_s = 1'b0;
        endcase
    end

    // State register, R-type latch and retired-instruction counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            r_type_r  <= 1'b0;
            retired_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == DECODE) begin
                r_type_r <= (input_opcode == OP_R);
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Per-state decode of datapath selects and strobes
    always_comb begin
        output_ALUOp    = ALU_ADD;
        output_ALUSrcA  = 2'd0;
        output_ALUSrcB  = 2'd0;
        output_PCSrc    = 1'b0;
        output_PCWrite  = 1'b0;
        output_IRWrite  = 1'b0;
        output_MemRead  = 1'b0;
        output_MemWrite = 1'b0;
        output_IorD     = 1'b0;
        output_RegWrite = 1'b0;
        output_MemtoReg = 1'b0;
        output_RegDst   = 1'b0;
        case (state_r)
            FETCH: begin
                output_MemRead = 1'b1;
                output_ALUSrcB = 2'd1;
                output_IRWrite = input_mem_ready;
                output_PCWrite = input_mem_ready;
            end
            DECODE: begin
                output_ALUSrcB = 2'd2;
            end
            EXEC_R: begin
                output_ALUSrcA = 2'd2;
                output_ALUOp   = input_funct;
            end
            EXEC_I, MEM_ADDR: begin
                output_ALUSrcA = 2'd2;
                output_ALUSrcB = 2'd2;
            end
            ALU_WB: begin
                output_RegWrite = 1'b1;
                output_RegDst   = r_type_r;
            end
            MEM_READ: begin
                output_MemRead = 1'b1;
                output_IorD    = 1'b1;
            end
            MEM_WB: begin
                output_RegWrite = 1'b1;
                output_MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                output_MemWrite = 1'b1;
                output_IorD     = 1'b1;
            end
            BRANCH: begin
                output_ALUSrcA = 2'd2;
                output_ALUOp   = ALU_SUB;
                output_PCSrc   = 1'b1;
                output_PCWrite = branch_taken_s;
            end
            JUMP: begin
                output_ALUSrcA = 2'd3;
                output_ALUSrcB = 2'd3;
                output_PCWrite = 1'b1;
            end
            // IDLE and HALT drive no strobes
            default: begin
                output_ALUOp = ALU_ADD;
            end
        endcase
    end

    assign output_state   = state_r;
    assign output_illegal = illegal_s;
    assign output_halted  = (state_r == HALT);
    assign output_retired = retired_r;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Testbench for multi_cycle_control: directed instruction sequences, a
// per-instruction expectation model built from the opcode semantics, and a
// single compare process that checks every output on every cycle.

module tb_multi_cycle_control;

    localparam int RW = 8;   // narrow counter so wrap-around is reachable quickly

`ifdef CONTROL_BLT_EN
    localparam bit BLT_ON = 1'b1;
`else
    localparam bit BLT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    input_opcode;
    logic [2:0]    input_funct;
    logic          input_Zero;
    logic          input_negative;
    logic          input_mem_ready;
    logic [2:0]    output_ALUOp;
    logic [1:0]    output_ALUSrcA;
    logic [1:0]    output_ALUSrcB;
    logic          output_PCSrc;
    logic          output_PCWrite;
    logic          output_IRWrite;
    logic          output_MemRead;
    logic          output_MemWrite;
    logic          output_IorD;
    logic          output_RegWrite;
    logic          output_MemtoReg;
    logic          output_RegDst;
    logic [3:0]    output_state;
    logic          output_illegal;
    logic          output_halted;
    logic [RW-1:0] output_retired;

    always #5 clk = ~clk;

    multi_cycle_control #(.RETIRE_W(RW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .input_opcode    (input_opcode),
        .input_funct     (input_funct),
        .input_Zero      (input_Zero),
        .input_negative  (input_negative),
        .input_mem_ready (input_mem_ready),
        .output_ALUOp    (output_ALUOp),
        .output_ALUSrcA  (output_ALUSrcA),
        .output_ALUSrcB  (output_ALUSrcB),
        .output_PCSrc    (output_PCSrc),
        .output_PCWrite  (output_PCWrite),
        .output_IRWrite  (output_IRWrite),
        .output_MemRead  (output_MemRead),
        .output_MemWrite (output_MemWrite),
        .output_IorD     (output_IorD),
        .output_RegWrite (output_RegWrite),
        .output_MemtoReg (output_MemtoReg),
        .output_RegDst   (output_RegDst),
        .output_state    (output_state),
        .output_illegal  (output_illegal),
        .output_halted   (output_halted),
        .output_retired  (output_retired)
    );

    typedef struct packed {
        logic [3:0]    st;
        logic [2:0]    aluop;
        logic [1:0]    srca;
        logic [1:0]    srcb;
        logic          pcsrc;
        logic          pcwrite;
        logic          irwrite;
        logic          memread;
        logic          memwrite;
        logic          iord;
        logic          regwrite;
        logic          memtoreg;
        logic          regdst;
        logic          illegal;
        logic          halted;
        logic [RW-1:0] retired;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   mdl_ret = 0;
    int   cyc     = 0;
    int   cycles;
    int   ret_before;

    // One expectation for a cycle in the given state with everything else idle
    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e         = '0;
        e.st      = st;
        e.retired = mdl_ret[RW-1:0];
        return e;
    endfunction

    function automatic bit legal(input logic [3:0] op);
        if (op <= 4'd6 || op == 4'd15) return 1'b1;
        else if (op == 4'd7)           return BLT_ON;
        else                           return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic retire();
        mdl_ret = (mdl_ret + 1) % (1 << RW);
    endtask

    // Drive one instruction and queue the expected outputs of every cycle
    task automatic run_instr(input logic [3:0] op, input logic [2:0] fn,
                             input logic z, input logic n,
                             input int fstall, input int mstall, output int ncyc);
        exp_t e;
        cyc            = 0;
        input_opcode   = op;
        input_funct    = fn;
        input_Zero     = z;
        input_negative = n;
        for (int i = 0; i < fstall; i++) begin
            input_mem_ready = 1'b0;
            e = blank(4'd1); e.memread = 1'b1; e.srcb = 2'd1;
            q.push_back(e); step();
        end
        input_mem_ready = 1'b1;
        e = blank(4'd1); e.memread = 1'b1; e.srcb = 2'd1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
        q.push_back(e); step();
        e = blank(4'd2); e.srcb = 2'd2; e.illegal = !legal(op);
        q.push_back(e); step();
        if (legal(op)) begin
            case (op)
                4'd0, 4'd1: begin
                    e = blank((op == 4'd0) ? 4'd3 : 4'd4);
                    e.srca  = 2'd2;
                    e.srcb  = (op == 4'd0) ? 2'd0 : 2'd2;
                    e.aluop = (op == 4'd0) ? fn : 3'd0;
                    q.push_back(e); step();
                    e = blank(4'd5); e.regwrite = 1'b1; e.regdst = (op == 4'd0);
                    q.push_back(e); retire(); step();
                end
                4'd2, 4'd3: begin
                    e = blank(4'd6); e.srca = 2'd2; e.srcb = 2'd2;
                    q.push_back(e); step();
                    for (int i = 0; i <= mstall; i++) begin
                        input_mem_ready = (i == mstall);
                        e = blank((op == 4'd2) ? 4'd7 : 4'd9);
                        e.iord = 1'b1;
                        if (op == 4'd2) e.memread = 1'b1;
                        else            e.memwrite = 1'b1;
                        q.push_back(e);
                        if (op == 4'd3 && i == mstall) retire();
                        step();
                    end
                    if (op == 4'd2) begin
                        e = blank(4'd8); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                        q.push_back(e); retire(); step();
                    end
                end
                4'd4, 4'd5, 4'd7: begin
                    e = blank(4'd10); e.srca = 2'd2; e.aluop = 3'd1; e.pcsrc = 1'b1;
                    e.pcwrite = (op == 4'd4) ? z : ((op == 4'd5) ? !z : n);
                    q.push_back(e); retire(); step();
                end
                4'd6: begin
                    e = blank(4'd11); e.srca = 2'd3; e.srcb = 2'd3; e.pcwrite = 1'b1;
                    q.push_back(e); retire(); step();
                end
                default: begin
                    for (int i = 0; i < 20; i++) begin
                        input_mem_ready = i[0];
                        input_Zero      = i[1];
                        input_negative  = i[2];
                        e = blank(4'd12); e.halted = 1'b1;
                        q.push_back(e); step();
                    end
                end
            endcase
        end
        ncyc = cyc;
    endtask

    initial begin
        reset_n         = 1'b0;
        input_opcode    = 4'd0;
        input_funct     = 3'd0;
        input_Zero      = 1'b0;
        input_negative  = 1'b0;
        input_mem_ready = 1'b1;

        // Every-cycle comparison of all outputs against the queued model
        fork
            forever begin
                exp_t e;
                exp_t a;
                @(negedge clk);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    a = {output_state, output_ALUOp, output_ALUSrcA, output_ALUSrcB,
                         output_PCSrc, output_PCWrite, output_IRWrite, output_MemRead,
                         output_MemWrite, output_IorD, output_RegWrite, output_MemtoReg,
                         output_RegDst, output_illegal, output_halted, output_retired};
                    n_total++;
                    if (a === e) n_pass++;
                    else $display("FAIL cycle_cmp t=%0t state actual=%0d required=%0d vector actual=%h required=%h",
                                  $time, a.st, e.st, a, e);
                end
            end
        join_none

        // Reset held for three cycles
        step();
        for (int i = 0; i < 3; i++) begin
            q.push_back(blank(4'd0)); step();
        end
        check("reset_state", {28'd0, output_state}, 32'd0);
        check("reset_retired", {24'd0, output_retired}, 32'd0);
        reset_n = 1'b1;
        q.push_back(blank(4'd0)); step();

        run_instr(4'd0, 3'd2, 1'b0, 1'b0, 0, 0, cycles);
        check("r_latency", cycles, 32'd4);
        check("r_retired", {24'd0, output_retired}, 32'd1);
        check("r_next_fetch", {28'd0, output_state}, 32'd1);

        run_instr(4'd1, 3'd5, 1'b0, 1'b0, 0, 0, cycles);
        check("addi_latency", cycles, 32'd4);
        run_instr(4'd2, 3'd0, 1'b0, 1'b0, 0, 2, cycles);
        check("lw_stall_latency", cycles, 32'd7);
        run_instr(4'd2, 3'd0, 1'b0, 1'b0, 1, 0, cycles);
        check("lw_fetch_stall_latency", cycles, 32'd6);
        run_instr(4'd3, 3'd0, 1'b0, 1'b0, 0, 0, cycles);
        check("sw_latency", cycles, 32'd4);
        run_instr(4'd3, 3'd0, 1'b0, 1'b0, 0, 1, cycles);
        run_instr(4'd4, 3'd0, 1'b1, 1'b0, 0, 0, cycles);
        check("beq_latency", cycles, 32'd3);
        run_instr(4'd5, 3'd0, 1'b1, 1'b0, 0, 0, cycles);
        run_instr(4'd5, 3'd0, 1'b0, 1'b1, 0, 0, cycles);
        run_instr(4'd4, 3'd0, 1'b0, 1'b1, 0, 0, cycles);
        run_instr(4'd6, 3'd0, 1'b1, 1'b1, 0, 0, cycles);
        check("j_latency", cycles, 32'd3);
        run_instr(4'd0, 3'd7, 1'b0, 1'b0, 0, 0, cycles);
        check("retired_after_12", {24'd0, output_retired}, 32'd12);

        ret_before = 12;
        run_instr(4'd9, 3'd0, 1'b0, 1'b0, 0, 0, cycles);
        check("illegal_latency", cycles, 32'd2);
        check("illegal_not_retired", {24'd0, output_retired}, ret_before);
        run_instr(4'd7, 3'd0, 1'b0, 1'b1, 0, 0, cycles);
        check("op7_latency", cycles, BLT_ON ? 32'd3 : 32'd2);
        check("op7_retired", {24'd0, output_retired}, BLT_ON ? 32'd13 : 32'd12);

        // Reset dropped in the middle of a store
        input_opcode = 4'd3;
        run_instr(4'd1, 3'd0, 1'b0, 1'b0, 0, 0, cycles);
        input_opcode = 4'd3;
        begin
            exp_t e;
            e = blank(4'd1); e.memread = 1'b1; e.srcb = 2'd1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
            q.push_back(e); step();
            e = blank(4'd2); e.srcb = 2'd2;
            q.push_back(e); step();
            e = blank(4'd6); e.srca = 2'd2; e.srcb = 2'd2;
            q.push_back(e); step();
            input_mem_ready = 1'b0;
            e = blank(4'd9); e.memwrite = 1'b1; e.iord = 1'b1;
            q.push_back(e);
        end
        @(negedge clk);
        #2;
        check("sw_memwrite_before_reset", {31'd0, output_MemWrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_memwrite_drop", {31'd0, output_MemWrite}, 32'd0);
        check("async_state_idle", {28'd0, output_state}, 32'd0);
        check("async_retired_zero", {24'd0, output_retired}, 32'd0);
        mdl_ret = 0;
        step();
        reset_n         = 1'b1;
        input_mem_ready = 1'b1;
        q.push_back(blank(4'd0)); step();

        // Counter wrap
        for (int i = 0; i < (1 << RW); i++) begin
            run_instr(4'd1, 3'd0, 1'b0, 1'b0, 0, 0, cycles);
            if (i == (1 << RW) - 2) check("retired_before_wrap", {24'd0, output_retired}, 32'd255);
        end
        check("retired_wrapped", {24'd0, output_retired}, 32'd0);

        // Halt persists until reset
        run_instr(4'd15, 3'd0, 1'b0, 1'b0, 0, 0, cycles);
        check("halted_high", {31'd0, output_halted}, 32'd1);
        check("halt_state", {28'd0, output_state}, 32'd12);
        reset_n = 1'b0;
        #1;
        check("halted_cleared", {31'd0, output_halted}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("restart_fetch", {28'd0, output_state}, 32'd1);
        check("queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
